// File: rtl/rv32i_pipe_pkg.sv
// ============================================================================
// rv32i_pipe_pkg : shared constants, stage record and operand-use decode
//                  for the RV32I 5-stage pipeline control path.
// Revision       : 1.0
// ============================================================================
`default_nettype none

package rv32i_pipe_pkg;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [31:0] inst;
    logic        rd_wren;
    logic        is_load;
  } stage_ctrl_t;

  function automatic logic rs1_used(input logic [6:0] opcode);
    return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  endfunction

  function automatic logic rs2_used(input logic [6:0] opcode);
    return (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : one pipeline stage control record with hold and bubble.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter logic [31:0] NOP_INST = rv32i_pipe_pkg::NOP_INST
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_hold,
  input  logic                        i_bubble,
  input  rv32i_pipe_pkg::stage_ctrl_t i_d,
  output rv32i_pipe_pkg::stage_ctrl_t o_q
);
  import rv32i_pipe_pkg::*;

  localparam stage_ctrl_t BUBBLE = {NOP_INST, 1'b0, 1'b0};

  stage_ctrl_t stage_d;
  stage_ctrl_t stage_q;

  // Hold wins over bubble so a frozen pipeline never loses its contents.
  always_comb begin
    stage_d = stage_q;
    if (!i_hold) begin
      stage_d = i_bubble ? BUBBLE : i_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stage_q <= BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_q = stage_q;

endmodule

`default_nettype wire

// File: rtl/hazard_pipe_ctrl.sv
// ============================================================================
// hazard_pipe_ctrl : EX/MEM/WB shadow registers, load-use and mispredict
//                    handling. Optional macro HAZARD_PERF_CNT_EN adds
//                    saturating stall/flush event counters.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module hazard_pipe_ctrl #(
  parameter logic [31:0] NOP_INST = rv32i_pipe_pkg::NOP_INST
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_ID_inst,
  input  logic        i_ID_rd_wren,
  input  logic        i_ID_is_load,
  input  logic        i_EX_mispredict,
  input  logic        i_dmem_stall,
  output logic [31:0] o_EX_inst,
  output logic        o_EX_rd_wren,
  output logic [31:0] o_MEM_inst,
  output logic        o_MEM_rd_wren,
  output logic [31:0] o_WB_inst,
  output logic        o_WB_rd_wren,
  output logic        o_pc_stall,
  output logic        o_IF_ID_stall,
  output logic        o_IF_ID_flush,
  output logic        o_ID_EX_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);
  import rv32i_pipe_pkg::*;

  stage_ctrl_t id_ctrl;
  stage_ctrl_t ex_q;
  stage_ctrl_t mem_q;
  stage_ctrl_t wb_q;

  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] ex_rd;
  logic       load_use;
  logic       ex_bubble;
  logic       unused_bits;

  assign id_ctrl   = {i_ID_inst, i_ID_rd_wren, i_ID_is_load};
  assign id_opcode = i_ID_inst[6:0];
  assign id_rs1    = i_ID_inst[19:15];
  assign id_rs2    = i_ID_inst[24:20];
  assign ex_rd     = ex_q.inst[11:7];

  always_comb begin
    load_use = ex_q.is_load & ex_q.rd_wren & (ex_rd != 5'd0) &
               ((rs1_used(id_opcode) & (ex_rd == id_rs1)) |
                (rs2_used(id_opcode) & (ex_rd == id_rs2)));
  end

  // A mispredict squashes the wrong-path ID instruction, so it also covers load-use.
  assign ex_bubble = i_EX_mispredict | load_use;

  pipe_stage_reg #(.NOP_INST(NOP_INST)) u_ex_reg (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_hold   (i_dmem_stall),
    .i_bubble (ex_bubble),
    .i_d      (id_ctrl),
    .o_q      (ex_q)
  );

  pipe_stage_reg #(.NOP_INST(NOP_INST)) u_mem_reg (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_hold   (i_dmem_stall),
    .i_bubble (1'b0),
    .i_d      (ex_q),
    .o_q      (mem_q)
  );

  pipe_stage_reg #(.NOP_INST(NOP_INST)) u_wb_reg (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_hold   (i_dmem_stall),
    .i_bubble (1'b0),
    .i_d      (mem_q),
    .o_q      (wb_q)
  );

  assign o_EX_inst     = ex_q.inst;
  assign o_EX_rd_wren  = ex_q.rd_wren;
  assign o_MEM_inst    = mem_q.inst;
  assign o_MEM_rd_wren = mem_q.rd_wren;
  assign o_WB_inst     = wb_q.inst;
  assign o_WB_rd_wren  = wb_q.rd_wren;

  assign o_pc_stall    = i_dmem_stall | (~i_EX_mispredict & load_use);
  assign o_IF_ID_stall = i_dmem_stall | (~i_EX_mispredict & load_use);
  assign o_IF_ID_flush = ~i_dmem_stall & i_EX_mispredict;
  assign o_ID_EX_flush = ~i_dmem_stall & ex_bubble;

  assign unused_bits = ^{mem_q.is_load, wb_q.is_load, i_ID_inst[31:25], i_ID_inst[14:7]};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_d;
  logic [31:0] flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!i_dmem_stall) begin
      if (!i_EX_mispredict && load_use && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (i_EX_mispredict && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_d = flush_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_pipe_ctrl.sv
// ============================================================================
// tb_hazard_pipe_ctrl : directed scenarios plus randomized traffic against
//                       an instruction-level reference of the hazard rules.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_pipe_ctrl;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] ADDI_X1_5    = 32'h0050_0093;
  localparam logic [31:0] ADD_X2_X1_X1 = 32'h0010_8133;
  localparam logic [31:0] LW_X5        = 32'h0000_A283;
  localparam logic [31:0] ADD_X6_X5_X0 = 32'h0002_8333;
  localparam logic [31:0] LW_X0        = 32'h0000_A003;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h0000_0333;
  localparam logic [31:0] LUI_X5_1     = 32'h0000_12B7;
  localparam logic [31:0] LUI_X5_28    = 32'h0002_82B7; // rs1 field aliases x5

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_ID_inst = NOP;
  logic        i_ID_rd_wren = 1'b0;
  logic        i_ID_is_load = 1'b0;
  logic        i_EX_mispredict = 1'b0;
  logic        i_dmem_stall = 1'b0;
  logic [31:0] o_EX_inst, o_MEM_inst, o_WB_inst;
  logic        o_EX_rd_wren, o_MEM_rd_wren, o_WB_rd_wren;
  logic        o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] o_stall_cnt, o_flush_cnt;
  int unsigned m_stall_cnt, m_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference pipeline contents: index 0 = EX, 1 = MEM, 2 = WB.
  logic [31:0] m_inst [3];
  logic        m_wren [3];
  logic        m_load [3];

  hazard_pipe_ctrl dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_ID_inst       (i_ID_inst),
    .i_ID_rd_wren    (i_ID_rd_wren),
    .i_ID_is_load    (i_ID_is_load),
    .i_EX_mispredict (i_EX_mispredict),
    .i_dmem_stall    (i_dmem_stall),
    .o_EX_inst       (o_EX_inst),
    .o_EX_rd_wren    (o_EX_rd_wren),
    .o_MEM_inst      (o_MEM_inst),
    .o_MEM_rd_wren   (o_MEM_rd_wren),
    .o_WB_inst       (o_WB_inst),
    .o_WB_rd_wren    (o_WB_rd_wren),
    .o_pc_stall      (o_pc_stall),
    .o_IF_ID_stall   (o_IF_ID_stall),
    .o_IF_ID_flush   (o_IF_ID_flush),
    .o_ID_EX_flush   (o_ID_EX_flush)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_stall_cnt     (o_stall_cnt),
    .o_flush_cnt     (o_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit ref_hazard();
    int op, rd, rs1, rs2;
    bit uses1, uses2;
    op    = int'(i_ID_inst) & 32'h7F;
    rs1   = (int'(i_ID_inst) >> 15) & 31;
    rs2   = (int'(i_ID_inst) >> 20) & 31;
    rd    = (int'(m_inst[0]) >> 7) & 31;
    uses1 = !(op == 'h37 || op == 'h17 || op == 'h6F);
    uses2 = (op == 'h33 || op == 'h23 || op == 'h63);
    return m_load[0] && m_wren[0] && rd != 0 &&
           ((uses1 && rd == rs1) || (uses2 && rd == rs2));
  endfunction

  // {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush}
  function automatic logic [3:0] ref_ctrl();
    if (i_dmem_stall)    return 4'b1100;
    if (i_EX_mispredict) return 4'b0011;
    if (ref_hazard())    return 4'b1101;
    return 4'b0000;
  endfunction

  task automatic ref_reset();
    for (int s = 0; s < 3; s++) begin
      m_inst[s] = NOP;
      m_wren[s] = 1'b0;
      m_load[s] = 1'b0;
    end
`ifdef HAZARD_PERF_CNT_EN
    m_stall_cnt = 0;
    m_flush_cnt = 0;
`endif
  endtask

  task automatic ref_advance();
    bit bub;
    if (i_dmem_stall) return;
    bub = i_EX_mispredict || ref_hazard();
`ifdef HAZARD_PERF_CNT_EN
    if (i_EX_mispredict && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    else if (bub && !i_EX_mispredict && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
`endif
    for (int s = 2; s > 0; s--) begin
      m_inst[s] = m_inst[s-1];
      m_wren[s] = m_wren[s-1];
      m_load[s] = m_load[s-1];
    end
    m_inst[0] = bub ? NOP : i_ID_inst;
    m_wren[0] = bub ? 1'b0 : i_ID_rd_wren;
    m_load[0] = bub ? 1'b0 : i_ID_is_load;
  endtask

  task automatic drive(input logic [31:0] inst, input logic wren, input logic ld,
                       input logic misp, input logic dst);
    i_ID_inst       = inst;
    i_ID_rd_wren    = wren;
    i_ID_is_load    = ld;
    i_EX_mispredict = misp;
    i_dmem_stall    = dst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    ref_advance();
    #1;
  endtask

  task automatic apply_reset();
    i_reset = 1'b1;
    ref_reset();
    #1;
    i_reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    i_reset = 1'b1;
    ref_reset();
    #2;
    checks++;
    if (o_EX_inst !== NOP) begin
      errors++; $display("FAIL reset_ex_inst: got %h expected %h", o_EX_inst, NOP);
    end
    checks++;
    if ({o_MEM_inst, o_WB_inst} !== {NOP, NOP}) begin
      errors++; $display("FAIL reset_mem_wb_inst: got %h/%h expected %h", o_MEM_inst, o_WB_inst, NOP);
    end
    checks++;
    if ({o_EX_rd_wren, o_MEM_rd_wren, o_WB_rd_wren} !== 3'b000) begin
      errors++; $display("FAIL reset_wren: got %b expected 000", {o_EX_rd_wren, o_MEM_rd_wren, o_WB_rd_wren});
    end
    checks++;
    if ({o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush});
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({o_stall_cnt, o_flush_cnt} !== 64'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", o_stall_cnt, o_flush_cnt);
    end
`endif
    i_reset = 1'b0;
    #1;
  endtask

  task automatic test_forward();
    apply_reset();
    drive(ADDI_X1_5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(ADD_X2_X1_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_pc_stall !== 1'b0) begin
      errors++; $display("FAIL fwd_no_stall: got %b expected 0", o_pc_stall);
    end
    tick();
    checks++;
    if ({o_EX_inst, o_MEM_inst} !== {ADD_X2_X1_X1, ADDI_X1_5}) begin
      errors++; $display("FAIL fwd_ex_mem: got %h/%h expected %h/%h", o_EX_inst, o_MEM_inst, ADD_X2_X1_X1, ADDI_X1_5);
    end
    checks++;
    if ({o_EX_rd_wren, o_MEM_rd_wren, o_pc_stall} !== 3'b110) begin
      errors++; $display("FAIL fwd_wren_stall: got %b expected 110", {o_EX_rd_wren, o_MEM_rd_wren, o_pc_stall});
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADD_X6_X5_X0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush} !== 4'b1101) begin
      errors++; $display("FAIL lu_ctrl: got %b expected 1101", {o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush});
    end
    tick();
    checks++;
    if ({o_EX_inst, o_MEM_inst, o_EX_rd_wren} !== {NOP, LW_X5, 1'b0}) begin
      errors++; $display("FAIL lu_bubble: got %h/%h/%b expected %h/%h/0", o_EX_inst, o_MEM_inst, o_EX_rd_wren, NOP, LW_X5);
    end
    checks++;
    if ({o_pc_stall, o_ID_EX_flush} !== 2'b00) begin
      errors++; $display("FAIL lu_single_bubble: got %b expected 00", {o_pc_stall, o_ID_EX_flush});
    end
    tick();
    checks++;
    if ({o_EX_inst, o_WB_inst} !== {ADD_X6_X5_X0, LW_X5}) begin
      errors++; $display("FAIL lu_resume: got %h/%h expected %h/%h", o_EX_inst, o_WB_inst, ADD_X6_X5_X0, LW_X5);
    end
  endtask

  task automatic test_no_stall_cases();
    apply_reset();
    drive(LW_X0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADD_X6_X0_X0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_pc_stall, o_ID_EX_flush} !== 2'b00) begin
      errors++; $display("FAIL x0_no_stall: got %b expected 00", {o_pc_stall, o_ID_EX_flush});
    end
    tick();
    drive(LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(LUI_X5_1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_pc_stall, o_ID_EX_flush} !== 2'b00) begin
      errors++; $display("FAIL lui_no_stall: got %b expected 00", {o_pc_stall, o_ID_EX_flush});
    end
    drive(LUI_X5_28, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_pc_stall, o_ID_EX_flush} !== 2'b00) begin
      errors++; $display("FAIL lui_rs1_alias: got %b expected 00", {o_pc_stall, o_ID_EX_flush});
    end
  endtask

  task automatic test_mispredict();
    apply_reset();
    drive(LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADD_X6_X5_X0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush} !== 4'b0011) begin
      errors++; $display("FAIL misp_ctrl: got %b expected 0011", {o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush});
    end
    tick();
    checks++;
    if ({o_EX_inst, o_EX_rd_wren, o_MEM_inst} !== {NOP, 1'b0, LW_X5}) begin
      errors++; $display("FAIL misp_bubble: got %h/%b/%h expected %h/0/%h", o_EX_inst, o_EX_rd_wren, o_MEM_inst, NOP, LW_X5);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({o_stall_cnt, o_flush_cnt} !== {32'd0, 32'd1}) begin
      errors++; $display("FAIL misp_counters: got %0d/%0d expected 0/1", o_stall_cnt, o_flush_cnt);
    end
`endif
  endtask

  task automatic test_dmem_stall();
    apply_reset();
    drive(LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(ADD_X6_X5_X0, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush} !== 4'b1100) begin
        errors++; $display("FAIL dstall_ctrl[%0d]: got %b expected 1100", c, {o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush});
      end
      checks++;
      if ({o_EX_inst, o_MEM_inst, o_WB_inst} !== {LW_X5, NOP, NOP}) begin
        errors++; $display("FAIL dstall_frozen[%0d]: got %h/%h/%h expected %h/%h/%h", c, o_EX_inst, o_MEM_inst, o_WB_inst, LW_X5, NOP, NOP);
      end
      tick();
    end
    drive(ADD_X6_X5_X0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush} !== 4'b1101) begin
      errors++; $display("FAIL dstall_then_lu: got %b expected 1101", {o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush});
    end
    tick();
    checks++;
    if ({o_EX_inst, o_MEM_inst, o_pc_stall} !== {NOP, LW_X5, 1'b0}) begin
      errors++; $display("FAIL dstall_one_bubble: got %h/%h/%b expected %h/%h/0", o_EX_inst, o_MEM_inst, o_pc_stall, NOP, LW_X5);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (o_stall_cnt !== 32'd1) begin
      errors++; $display("FAIL dstall_stall_cnt: got %0d expected 1", o_stall_cnt);
    end
`endif
    drive(ADD_X6_X5_X0, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    i_reset = 1'b1;
    ref_reset();
    #1;
    checks++;
    if ({o_EX_inst, o_MEM_inst, o_WB_inst, o_EX_rd_wren, o_MEM_rd_wren} !== {NOP, NOP, NOP, 2'b00}) begin
      errors++; $display("FAIL midstall_reset: got %h/%h/%h/%b%b expected NOP state", o_EX_inst, o_MEM_inst, o_WB_inst, o_EX_rd_wren, o_MEM_rd_wren);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (o_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL midstall_reset_cnt: got %0d expected 0", o_stall_cnt);
    end
`endif
    i_reset = 1'b0;
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0]   ops [9];
    logic [6:0]   op;
    logic [4:0]   rd, rs1, rs2;
    logic [102:0] got, exp;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      op  = ops[$urandom_range(0, 8)];
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      drive({7'd0, rs2, rs1, 3'b010, rd, op},
            (op == 7'h23 || op == 7'h63) ? 1'b0 : 1'($urandom_range(0, 1) | (op == 7'h03)),
            (op == 7'h03),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 6) == 0));
      got = {o_EX_inst, o_EX_rd_wren, o_MEM_inst, o_MEM_rd_wren, o_WB_inst, o_WB_rd_wren,
             o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_flush};
      exp = {m_inst[0], m_wren[0], m_inst[1], m_wren[1], m_inst[2], m_wren[2], ref_ctrl()};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", n, got, exp);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if ({o_stall_cnt, o_flush_cnt} !== {m_stall_cnt, m_flush_cnt}) begin
        errors++; $display("FAIL random_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, o_stall_cnt, o_flush_cnt, m_stall_cnt, m_flush_cnt);
      end
`endif
      if ($urandom_range(0, 99) == 0) begin
        apply_reset();
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    ref_reset();
    test_reset();
    test_forward();
    test_load_use();
    test_no_stall_cases();
    test_mispredict();
    test_dmem_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
